wb_uart_tx: RTL and testbench

Wishbone-slave UART peripheral on the split read/write Wishbone host bus of the memory-mapped register stage, occupying a 4-word window above the machine-timer registers.
- Holds a byte FIFO that feeds an 8N1 serial transmitter with a programmable baud divisor.
- Returns registered read data with a single-cycle ack, matching the host's one-cycle ack/data capture.
- Optional receiver compiled in by macro.

---
 rtl/wb_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx.sv
// Wishbone-slave UART: byte FIFO feeding an 8N1 transmitter with a programmable baud divisor.
// Define UART_RX_EN to compile in the optional receiver (STATUS bits 6:4 and RXDATA at +2).

`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_BYTES
`define XLEN_BYTES 4
`endif
`ifndef MM_REG_ADDR_BITS
`define MM_REG_ADDR_BITS 8
`endif

module wb_uart_tx #(
  parameter int BASE_ADDR        = 4,
  parameter int FIFO_DEPTH_LOG2  = 3,
  parameter int DEFAULT_BAUD_DIV = 867
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sync_reset,
  input  logic                         WB_RD_STB_I,
  input  logic [`MM_REG_ADDR_BITS-1:0] WB_RD_ADR_I,
  output logic [`XLEN-1:0]             WB_RD_DAT_O,
  output logic                         WB_RD_ACK_O,
  input  logic                         WB_WR_WE_I,
  input  logic [`XLEN_BYTES-1:0]       WB_WR_SEL_I,
  input  logic [`MM_REG_ADDR_BITS-1:0] WB_WR_ADR_I,
  input  logic [`XLEN-1:0]             WB_WR_DAT_I,
  output logic                         WB_WR_ACK_O,
  output logic                         TXD,
  input  logic                         RXD
);

  localparam int AW    = `MM_REG_ADDR_BITS;
  localparam int XW    = `XLEN;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [AW-1:0] BASE    = AW'(BASE_ADDR);
  localparam logic [15:0]   DIV_RST = 16'(DEFAULT_BAUD_DIV);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Subtracting the base makes addresses below the window wrap to large values, so one compare decodes both ends.
  logic [AW-1:0] rd_off, wr_off;
  logic          rd_hit, wr_hit, stat_rd;
  assign rd_off  = WB_RD_ADR_I - BASE;
  assign wr_off  = WB_WR_ADR_I - BASE;
  assign rd_hit  = WB_RD_STB_I && (rd_off < AW'(4));
  assign wr_hit  = WB_WR_WE_I  && (wr_off < AW'(4));
  assign stat_rd = rd_hit && (rd_off[1:0] == 2'd0);

  tx_state_e                  state_q;
  logic [7:0]                 shift_q;
  logic [15:0]                bit_cnt_q;
  logic [2:0]                 bit_idx_q;
  logic                       txd_q;
  logic [15:0]                baud_div_q, baud_div_d;
  logic                       overflow_q, overflow_d;
  logic                       rd_ack_q, wr_ack_q;
  logic [XW-1:0]              rd_dat_q, rd_dat_d;
  logic [7:0]                 fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic                       full, empty, busy, push_req, push, push_drop, pop;
  logic                       rx_valid, rx_ferr, rx_ovr;
  logic [7:0]                 rx_byte;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign busy      = (state_q != TX_IDLE) || !empty;
  assign pop       = !empty && ((state_q == TX_IDLE) || (state_q == TX_STOP && bit_cnt_q == '0));
  assign push_req  = wr_hit && (wr_off[1:0] == 2'd0) && WB_WR_SEL_I[0];
  assign push      = push_req && (!full || pop);
  assign push_drop = push_req && !push;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (sync_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= WB_WR_DAT_I[7:0];
  end

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    baud_div_d = baud_div_q;
    overflow_d = overflow_q;
    rd_dat_d   = '0;
    if (wr_hit && wr_off[1:0] == 2'd1) begin
      if (WB_WR_SEL_I[0]) baud_div_d[7:0]  = WB_WR_DAT_I[7:0];
      if (WB_WR_SEL_I[1]) baud_div_d[15:8] = WB_WR_DAT_I[15:8];
    end
    if (stat_rd)   overflow_d = 1'b0;
    if (push_drop) overflow_d = 1'b1;
    case (rd_off[1:0])
      2'd0:    rd_dat_d[15:0] = {8'(count_q), 1'b0, rx_ovr, rx_ferr, rx_valid,
                                 overflow_q, busy, empty, full};
      2'd1:    rd_dat_d[15:0] = baud_div_q;
      2'd2:    rd_dat_d = XW'({rx_valid, 23'b0, rx_byte});
      default: rd_dat_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_div_q <= DIV_RST;
      overflow_q <= 1'b0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_dat_q   <= '0;
    end else if (sync_reset) begin
      baud_div_q <= DIV_RST;
      overflow_q <= 1'b0;
      rd_ack_q   <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_dat_q   <= '0;
    end else begin
      baud_div_q <= baud_div_d;
      overflow_q <= overflow_d;
      rd_ack_q   <= rd_hit;
      wr_ack_q   <= wr_hit;
      if (rd_hit) rd_dat_q <= rd_dat_d;
    end
  end

  // A stop bit that ends with data waiting pops straight into START, so frames run back to back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
    end else if (sync_reset) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (pop) begin
            shift_q   <= fifo_mem[rd_ptr_q];
            bit_cnt_q <= baud_div_q;
            txd_q     <= 1'b0;
            state_q   <= TX_START;
          end
        end
        TX_START: begin
          if (bit_cnt_q == '0) begin
            bit_cnt_q <= baud_div_q;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= TX_DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_cnt_q == '0) begin
            bit_cnt_q <= baud_div_q;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_cnt_q == '0) begin
            if (pop) begin
              shift_q   <= fifo_mem[rd_ptr_q];
              bit_cnt_q <= baud_div_q;
              txd_q     <= 1'b0;
              state_q   <= TX_START;
            end else begin
              state_q <= TX_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

`ifdef UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e   rx_state_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_shift_q, rx_byte_q;
  logic        rx_valid_q, rx_ferr_q, rx_ovr_q;
  logic        rx_rd;
  logic [16:0] rx_div_p1;

  assign rx_rd     = rd_hit && (rd_off[1:0] == 2'd2);
  assign rx_div_p1 = {1'b0, baud_div_q} + 17'd1;
  assign rx_valid  = rx_valid_q;
  assign rx_ferr   = rx_ferr_q;
  assign rx_ovr    = rx_ovr_q;
  assign rx_byte   = rx_byte_q;

  // Read-clear sits before the frame logic so a byte completing in the same cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {rx_s1_q, rx_s2_q, rx_prev_q} <= 3'b111;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      {rx_valid_q, rx_ferr_q, rx_ovr_q} <= 3'b000;
    end else if (sync_reset) begin
      {rx_s1_q, rx_s2_q, rx_prev_q} <= 3'b111;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      {rx_valid_q, rx_ferr_q, rx_ovr_q} <= 3'b000;
    end else begin
      rx_s1_q   <= RXD;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (rx_rd) {rx_valid_q, rx_ferr_q, rx_ovr_q} <= 3'b000;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_cnt_q   <= rx_div_p1[16:1];
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            rx_cnt_q   <= baud_div_q;
            rx_idx_q   <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_cnt_q   <= baud_div_q;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_idx_q   <= rx_idx_q + 1'b1;
            if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == '0) begin
            rx_byte_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
            if (rx_valid_q) rx_ovr_q  <= 1'b1;
            if (!rx_s2_q)   rx_ferr_q <= 1'b1;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, WB_WR_DAT_I[XW-1:16], WB_WR_SEL_I[`XLEN_BYTES-1:2]};
`else
  assign rx_valid = 1'b0;
  assign rx_ferr  = 1'b0;
  assign rx_ovr   = 1'b0;
  assign rx_byte  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, RXD, WB_WR_DAT_I[XW-1:16], WB_WR_SEL_I[`XLEN_BYTES-1:2]};
`endif

  assign WB_RD_DAT_O = rd_dat_q;
  assign WB_RD_ACK_O = rd_ack_q;
  assign WB_WR_ACK_O = wr_ack_q;
  assign TXD         = txd_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed self-checking bench for wb_uart_tx: register access, frame timing, FIFO overflow and resets.
// The receiver scenario runs only when UART_RX_EN is defined.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_BYTES
`define XLEN_BYTES 4
`endif
`ifndef MM_REG_ADDR_BITS
`define MM_REG_ADDR_BITS 8
`endif

module tb_wb_uart_tx;

  localparam int AW = `MM_REG_ADDR_BITS;
  localparam logic [AW-1:0] A_STAT = AW'(4);
  localparam logic [AW-1:0] A_BAUD = AW'(5);
  localparam logic [AW-1:0] A_RX   = AW'(6);
  localparam logic [AW-1:0] A_RSV  = AW'(7);

  logic                   clk = 1'b0;
  logic                   reset_n, sync_reset;
  logic                   rd_stb, rd_ack, wr_we, wr_ack, txd, rxd;
  logic [AW-1:0]          rd_adr, wr_adr;
  logic [`XLEN-1:0]       rd_dat, wr_dat;
  logic [`XLEN_BYTES-1:0] wr_sel;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rxd = txd;

  wb_uart_tx dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .WB_RD_STB_I(rd_stb), .WB_RD_ADR_I(rd_adr), .WB_RD_DAT_O(rd_dat), .WB_RD_ACK_O(rd_ack),
    .WB_WR_WE_I(wr_we), .WB_WR_SEL_I(wr_sel), .WB_WR_ADR_I(wr_adr), .WB_WR_DAT_I(wr_dat),
    .WB_WR_ACK_O(wr_ack), .TXD(txd), .RXD(rxd)
  );

  task automatic wb_read(input logic [AW-1:0] adr, output logic [31:0] dat, output logic ack);
    @(negedge clk);
    rd_stb = 1'b1;
    rd_adr = adr;
    @(negedge clk);
    rd_stb = 1'b0;
    ack = rd_ack;
    dat = rd_dat;
  endtask

  task automatic wb_write(input logic [AW-1:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic ack);
    @(negedge clk);
    wr_we  = 1'b1;
    wr_adr = adr;
    wr_dat = dat;
    wr_sel = sel;
    @(negedge clk);
    wr_we = 1'b0;
    ack = wr_ack;
  endtask

  // Called at the negedge where j negedges have already elapsed since TXD fell; samples each bit mid-period.
  task automatic decode_frame(input int d, input int j0, output logic [7:0] b, output logic stop_bit);
    int j = j0;
    b = '0;
    stop_bit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      while (j < k * d + d / 2) begin
        @(negedge clk);
        j++;
      end
      if (k >= 1 && k <= 8) b[k-1] = txd;
      if (k == 9) stop_bit = txd;
    end
  endtask

  task automatic wait_fall(input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic a;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({txd, rd_ack, wr_ack} !== 3'b100) $display("FAIL reset_outputs: txd/rd_ack/wr_ack=%b expected 100", {txd, rd_ack, wr_ack});
    else n_pass++;
    n_checks++;
    if (rd_dat !== 32'h0) $display("FAIL reset_rd_dat: got %h expected 00000000", rd_dat);
    else n_pass++;
    reset_n = 1'b1;
    wb_read(A_STAT, d, a);
    n_checks++;
    if (a !== 1'b1 || d !== 32'h0000_0002) $display("FAIL reset_status: ack=%b data=%h expected ack=1 data=00000002", a, d);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rd_ack !== 1'b0 || rd_dat !== 32'h0000_0002) $display("FAIL rd_ack_single_hold: ack=%b data=%h expected ack=0 data=00000002", rd_ack, rd_dat);
    else n_pass++;
    wb_read(A_BAUD, d, a);
    n_checks++;
    if (a !== 1'b1 || d !== 32'h0000_0363) $display("FAIL reset_baud: ack=%b data=%h expected ack=1 data=00000363", a, d);
    else n_pass++;
  endtask

  task automatic test_decode;
    logic [31:0] d;
    logic a;
    wb_write(AW'(8), 32'h0000_0007, 4'hF, a);
    n_checks++;
    if (a !== 1'b0) $display("FAIL wr_miss_high_ack: ack=%b expected 0", a);
    else n_pass++;
    wb_write(AW'(3), 32'h0000_0007, 4'hF, a);
    n_checks++;
    if (a !== 1'b0) $display("FAIL wr_miss_low_ack: ack=%b expected 0", a);
    else n_pass++;
    wb_read(A_BAUD, d, a);
    n_checks++;
    if (d !== 32'h0000_0363) $display("FAIL miss_no_effect: baud=%h expected 00000363", d);
    else n_pass++;
    wb_read(AW'(3), d, a);
    n_checks++;
    if (a !== 1'b0 || d !== 32'h0000_0363) $display("FAIL rd_miss: ack=%b data=%h expected ack=0 data=00000363 held", a, d);
    else n_pass++;
    wb_read(A_RX, d, a);
    n_checks++;
    if (a !== 1'b1 || d !== 32'h0) $display("FAIL rxdata_idle: ack=%b data=%h expected ack=1 data=00000000", a, d);
    else n_pass++;
    wb_read(A_RSV, d, a);
    n_checks++;
    if (a !== 1'b1 || d !== 32'h0) $display("FAIL reserved_read: ack=%b data=%h expected ack=1 data=00000000", a, d);
    else n_pass++;
    wb_write(A_BAUD, 32'hFFFF_12FF, 4'b0010, a);
    n_checks++;
    if (a !== 1'b1) $display("FAIL baud_wr_ack: ack=%b expected 1", a);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (wr_ack !== 1'b0) $display("FAIL wr_ack_single: ack=%b expected 0", wr_ack);
    else n_pass++;
    wb_read(A_BAUD, d, a);
    n_checks++;
    if (d !== 32'h0000_1263) $display("FAIL baud_lane_write: data=%h expected 00001263", d);
    else n_pass++;
  endtask

  task automatic test_tx_frame;
    logic [31:0] d;
    logic a;
    logic [9:0] pat;
    pat = {1'b1, 8'hA5, 1'b0};
    wb_write(A_BAUD, 32'h0000_0003, 4'b0011, a);
    wb_write(A_STAT, 32'hFFFF_FFA5, 4'b0001, a);
    n_checks++;
    if (a !== 1'b1 || txd !== 1'b1) $display("FAIL push_a5: ack=%b txd=%b expected ack=1 txd=1", a, txd);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (txd !== pat[i/4]) $display("FAIL frame_a5_clk%0d: txd=%b expected %b", i, txd, pat[i/4]);
      else n_pass++;
    end
    wb_read(A_STAT, d, a);
    n_checks++;
    if (d !== 32'h0000_0002) $display("FAIL a5_done_status: data=%h expected 00000002", d);
    else n_pass++;
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    logic a, ok, sb;
    logic [7:0] b;
    int unsigned e2;
    logic [7:0] exp_b [9] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h77};
    wb_write(A_BAUD, 32'd100, 4'b0011, a);
    e2 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      wr_we  = 1'b1;
      wr_adr = A_STAT;
      wr_sel = 4'b0001;
      wr_dat = 32'h10 + k;
      if (k == 1) e2 = cyc + 1;
    end
    @(negedge clk);
    wr_we = 1'b0;
    wb_read(A_STAT, d, a);
    n_checks++;
    if (d !== 32'h0000_080D) $display("FAIL overflow_status1: data=%h expected 0000080d", d);
    else n_pass++;
    wb_read(A_STAT, d, a);
    n_checks++;
    if (d !== 32'h0000_0805) $display("FAIL overflow_cleared: data=%h expected 00000805", d);
    else n_pass++;
    // Push on the edge where the first stop bit ends and the next byte is popped.
    while (cyc < e2 + 1010 - 1) @(negedge clk);
    wr_we  = 1'b1;
    wr_adr = A_STAT;
    wr_sel = 4'b0001;
    wr_dat = 32'h77;
    @(negedge clk);
    wr_we = 1'b0;
    n_checks++;
    if (wr_ack !== 1'b1 || txd !== 1'b0) $display("FAIL push_at_pop: ack=%b txd=%b expected ack=1 txd=0", wr_ack, txd);
    else n_pass++;
    wb_read(A_STAT, d, a);
    n_checks++;
    if (d !== 32'h0000_0805) $display("FAIL push_at_pop_status: data=%h expected 00000805", d);
    else n_pass++;
    for (int f = 0; f < 9; f++) begin
      if (f > 0) begin
        wait_fall(200, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL frame%0d_start: no start bit within 200 cycles, expected one", f);
        else n_pass++;
      end
      decode_frame(101, (f == 0) ? 2 : 0, b, sb);
      n_checks++;
      if (b !== exp_b[f] || sb !== 1'b1) $display("FAIL frame%0d_byte: byte=%h stop=%b expected byte=%h stop=1", f, b, sb, exp_b[f]);
      else n_pass++;
    end
    repeat (60) @(negedge clk);
    wb_read(A_STAT, d, a);
    n_checks++;
    if (d !== 32'h0000_0002) $display("FAIL drained_status: data=%h expected 00000002", d);
    else n_pass++;
  endtask

  task automatic test_sync_reset;
    logic [31:0] d;
    logic a;
    wb_write(A_BAUD, 32'd3, 4'b0011, a);
    @(negedge clk);
    wr_we  = 1'b1;
    wr_adr = A_STAT;
    wr_sel = 4'b0001;
    wr_dat = 32'h55;
    rd_stb = 1'b1;
    rd_adr = A_STAT;
    @(negedge clk);
    wr_we  = 1'b0;
    rd_stb = 1'b0;
    n_checks++;
    if (rd_ack !== 1'b1 || rd_dat !== 32'h0000_0002 || wr_ack !== 1'b1) $display("FAIL simul_rd_push: rd_ack=%b data=%h wr_ack=%b expected 1/00000002/1", rd_ack, rd_dat, wr_ack);
    else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++;
    if (txd !== 1'b0) $display("FAIL mid_data_bit1: txd=%b expected 0", txd);
    else n_pass++;
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    n_checks++;
    if (txd !== 1'b1 || rd_dat !== 32'h0) $display("FAIL sync_reset_txd: txd=%b rd_dat=%h expected txd=1 rd_dat=00000000", txd, rd_dat);
    else n_pass++;
    wb_read(A_STAT, d, a);
    n_checks++;
    if (d !== 32'h0000_0002) $display("FAIL sync_reset_status: data=%h expected 00000002", d);
    else n_pass++;
    wb_read(A_BAUD, d, a);
    n_checks++;
    if (d !== 32'h0000_0363) $display("FAIL sync_reset_baud: data=%h expected 00000363", d);
    else n_pass++;
  endtask

`ifdef UART_RX_EN
  task automatic test_rx;
    logic [31:0] d;
    logic a;
    wb_write(A_BAUD, 32'd15, 4'b0011, a);
    wb_write(A_STAT, 32'h3C, 4'b0001, a);
    repeat (220) @(negedge clk);
    wb_read(A_STAT, d, a);
    n_checks++;
    if (d !== 32'h0000_0012) $display("FAIL rx_status_valid: data=%h expected 00000012", d);
    else n_pass++;
    wb_read(A_RX, d, a);
    n_checks++;
    if (d !== 32'h8000_003C) $display("FAIL rx_data: data=%h expected 8000003c", d);
    else n_pass++;
    wb_read(A_STAT, d, a);
    n_checks++;
    if (d !== 32'h0000_0002) $display("FAIL rx_valid_cleared: data=%h expected 00000002", d);
    else n_pass++;
    wb_write(A_STAT, 32'h3C, 4'b0001, a);
    wb_write(A_STAT, 32'h5A, 4'b0001, a);
    repeat (420) @(negedge clk);
    wb_read(A_STAT, d, a);
    n_checks++;
    if (d !== 32'h0000_0052) $display("FAIL rx_overrun: data=%h expected 00000052", d);
    else n_pass++;
    wb_read(A_RX, d, a);
    n_checks++;
    if (d !== 32'h8000_005A) $display("FAIL rx_overwrite: data=%h expected 8000005a", d);
    else n_pass++;
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    sync_reset = 1'b0;
    rd_stb     = 1'b0;
    rd_adr     = '0;
    wr_we      = 1'b0;
    wr_adr     = '0;
    wr_dat     = '0;
    wr_sel     = '0;
    test_reset;
    test_decode;
    test_tx_frame;
    test_overflow;
    test_sync_reset;
`ifdef UART_RX_EN
    test_rx;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
